mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative signed multiply/divide unit for the multicycle MIPS datapath (MULT, DIV).
//  Sits downstream of the register file: it takes the rs/rt read values (reg_a_out, reg_b_out) as its operands.
//  Runs for 32 cycles per operation and writes the results into architectural HI/LO registers.
//  The control FSM stalls on busy and waits for done; MFHI/MFLO read hi_out/lo_out.
// PARAMETERS
//  WIDTH   32  operand width; also the iteration count (one bit per cycle)
// PORTS
//  clk         in   1      clock; all state changes on rising edge
//  reset       in   1      asynchronous, active-low (0 = reset); one clock domain
//  a_in        in   WIDTH  operand A (rs): multiplicand or dividend
//  b_in        in   WIDTH  operand B (rt): multiplier or divisor
//  mult_start  in   1      request signed multiply; sampled only in IDLE
//  div_start   in   1      request signed divide; sampled only in IDLE
//  busy        out  1      high while state != IDLE
//  done        out  1      one-cycle pulse; HI/LO (or div_zero) valid in that cycle
//  div_zero    out  1      last DIV had divisor 0; holds until next accepted start
//  hi_out      out  WIDTH  HI: product[63:32] / remainder
//  lo_out      out  WIDTH  LO: product[31:0] / quotient
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0; datapath regs cleared.
//   - Reset mid-operation aborts the operation; no partial result reaches HI/LO.
//  FSM states IDLE -> RUN -> DONE -> IDLE.
//  IDLE, on the edge a start is seen:
//   - Latch |a|, |b|, the op, and result signs (sign_q = a^b; sign_r = a[31]).
//   - Clear div_zero; counter=0; go to RUN.
//   - Both starts high together: mult_start wins; div_start is ignored.
//   - DIV with b_in==0: div_zero=1, skip RUN, go straight to DONE; HI/LO stay unchanged.
//  RUN (exactly WIDTH edges, counter 0..WIDTH-1):
//   - MULT: shift-add on a 2*WIDTH accumulator.
//   - DIV: restoring shift-subtract with a WIDTH+1-bit partial remainder.
//   - On the last edge: apply signs (two's-complement negate), write HI/LO, go to DONE.
//  DONE: done=1 for exactly one cycle, busy=1; next edge returns to IDLE. No start is accepted in DONE.
//  Latency:
//   - start sampled at edge E0; HI/LO update at edge E32; done high in the cycle after E32.
//   - Divide-by-zero: done high in the cycle after E0.
//  Arithmetic rules:
//   - MULT: full 64-bit signed product; HI=upper 32 bits, LO=lower 32 bits.
//   - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
//   - 0x80000000 / -1: LO=0x80000000 (wraps), HI=0.
//   - |0x80000000| is handled as unsigned 0x80000000; no overflow flag.
//  Starts asserted while busy are ignored and are not queued.
//  Operands are used only at the start edge; later changes on a_in/b_in have no effect.
//  hi_out/lo_out hold their values between operations.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - MDU state encoding: IDLE, RUN, DONE.
//   - MDU_OP_MULT / MDU_OP_DIV.
//   - WIDTH default constant.
//  One sub-module is natural: mdu_div_step. It is combinational, one restoring-division step:
//   - rem_in, divisor -> rem_out, q_bit.
//  FSM, counter, accumulator and sign fix-up stay in this module.
// TESTING
//  1. mult 7 * 0xFFFFFFFD (-3) -> done in cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy 0 the cycle after.
//  2. div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), div_zero=0.
//  3. preload HI/LO via mult 3*5; then div 5/0 -> done in cycle 1, div_zero=1, HI=0, LO=15 unchanged.
//  4. mult 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5. div_start pulsed at cycle 5 of a running mult -> ignored; mult result correct, exactly one done.
//  6. reset low at cycle 10 of a div -> immediately busy=0, done=0, hi_out=lo_out=0.
//     New mult 2*2 after release -> LO=4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide unit state and op encodings, default width.
package cpu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef enum logic {
        MDU_OP_MULT = 1'b0,
        MDU_OP_DIV  = 1'b1
    } mdu_op_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes: subtract the divisor
// from the shifted partial remainder if it fits, producing one quotient bit.
module mdu_div_step
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // Remainder after a step is always below the divisor, so WIDTH bits suffice
    // and the subtraction can be done modulo 2^WIDTH.
    always_comb begin
        q_bit   = (rem_in >= {1'b0, divisor});
        rem_out = rem_in[WIDTH-1:0] - (q_bit ? divisor : '0);
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit (MULT/DIV) writing HI/LO.
// Operands are latched as magnitudes at start; 32 shift-add or restoring
// shift-subtract steps follow, and signs are applied on the final step.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mult_start,
    input  logic             div_start,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mult: {partial product, multiplier}; div: low half dividend->quotient
    logic [WIDTH-1:0]   rem_q, rem_d;      // div partial remainder
    logic [WIDTH-1:0]   opb_q, opb_d;      // |multiplicand| or |divisor|
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH:0]     div_rem_in;
    logic [WIDTH-1:0]   div_rem_out;
    logic               div_q_bit;
    logic [WIDTH-1:0]   div_quo;

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (div_rem_in),
        .divisor (opb_q),
        .rem_out (div_rem_out),
        .q_bit   (div_q_bit)
    );

    // Datapath step values: operand magnitudes, one multiply step, one divide step.
    always_comb begin
        abs_a      = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
        abs_b      = b_in[WIDTH-1] ? ('0 - b_in) : b_in;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_acc    = {mul_sum, acc_q[WIDTH-1:1]};
        mul_res    = neg_res_q ? ('0 - mul_acc) : mul_acc;
        div_rem_in = {rem_q, acc_q[WIDTH-1]};
        div_quo    = {acc_q[WIDTH-2:0], div_q_bit};
    end

    // Next-state, datapath update and HI/LO write-back.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        opb_d      = opb_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            MDU_IDLE: begin
                if (mult_start || div_start) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    div_zero_d = 1'b0;
                    neg_res_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                    neg_rem_d  = a_in[WIDTH-1];
                    if (mult_start) begin
                        op_d    = MDU_OP_MULT;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        opb_d   = abs_a;
                        state_d = MDU_RUN;
                    end else begin
                        op_d  = MDU_OP_DIV;
                        acc_d = {{WIDTH{1'b0}}, abs_a};
                        opb_d = abs_b;
                        if (b_in == '0) begin
                            div_zero_d = 1'b1;
                            state_d    = MDU_DONE;
                        end else begin
                            state_d = MDU_RUN;
                        end
                    end
                end
            end
            MDU_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == MDU_OP_MULT) begin
                    acc_d = mul_acc;
                end else begin
                    acc_d[WIDTH-1:0] = div_quo;
                    rem_d            = div_rem_out;
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = MDU_DONE;
                    if (op_q == MDU_OP_MULT) begin
                        hi_d = mul_res[2*WIDTH-1:WIDTH];
                        lo_d = mul_res[WIDTH-1:0];
                    end else begin
                        hi_d = neg_rem_q ? ('0 - div_rem_out) : div_rem_out;
                        lo_d = neg_res_q ? ('0 - div_quo) : div_quo;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= MDU_IDLE;
            op_q       <= MDU_OP_MULT;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            opb_q      <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            opb_q      <= opb_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = (state_q != MDU_IDLE);
    assign done     = (state_q == MDU_DONE);
    assign div_zero = div_zero_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .mult_start (mult_start),
        .div_start  (div_start),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    // Issue one start (called between edges) and wait for done; cycles=1 is the cycle after the start edge.
    task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b, output int cycles);
        a_in       = a;
        b_in       = b;
        mult_start = !is_div;
        div_start  = is_div;
        @(posedge clk); #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", hi_out); end
        n_checks++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", lo_out); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mult_basic();
        int cyc;
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, cyc);
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
        n_checks++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi_out); end
        n_checks++; if (lo_out !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", lo_out); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_in_done: got %b expected 1", busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_after: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %b expected 0", done); end
        @(posedge clk); #1;
        n_checks++; if (lo_out !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo_hold: got %h expected ffffffeb", lo_out); end
    endtask

    task automatic test_div_basic();
        int cyc;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, cyc);
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", cyc); end
        n_checks++; if (lo_out !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", lo_out); end
        n_checks++; if (hi_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", hi_out); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL div_div_zero: got %b expected 0", div_zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(1'b0, 32'd3, 32'd5, cyc);
        n_checks++; if (lo_out !== 32'd15) begin n_fail++; $display("FAIL preload_lo: got %h expected 0000000f", lo_out); end
        @(posedge clk); #1;
        run_op(1'b1, 32'd5, 32'd0, cyc);
        n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
        n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", div_zero); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL dz_hi: got %h expected 00000000", hi_out); end
        n_checks++; if (lo_out !== 32'd15) begin n_fail++; $display("FAIL dz_lo: got %h expected 0000000f", lo_out); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy_after: got %b expected 0", busy); end
        n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b expected 1", div_zero); end
    endtask

    task automatic test_min_values();
        int cyc;
        run_op(1'b0, 32'h80000000, 32'h80000000, cyc);
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL min_dz_cleared: got %b expected 0", div_zero); end
        n_checks++; if (hi_out !== 32'h40000000) begin n_fail++; $display("FAIL min_mult_hi: got %h expected 40000000", hi_out); end
        n_checks++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL min_mult_lo: got %h expected 00000000", lo_out); end
        @(posedge clk); #1;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_checks++; if (lo_out !== 32'h80000000) begin n_fail++; $display("FAIL min_div_lo: got %h expected 80000000", lo_out); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL min_div_hi: got %h expected 00000000", hi_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_signs();
        vec_t vecs [0:8];
        int   cyc;
        vecs[0] = '{1'b0, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00000000, 32'h00000040};
        vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[2] = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
        vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[5] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[6] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7] = '{1'b1, 32'd3,        32'd10,       32'd3,        32'd0};
        vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, cyc);
            n_checks++;
            if (hi_out !== vecs[i].hi || lo_out !== vecs[i].lo || cyc != 33) begin
                n_fail++;
                $display("FAIL signs_vec%0d: got hi=%h lo=%h cyc=%0d expected hi=%h lo=%h cyc=33",
                         i, hi_out, lo_out, cyc, vecs[i].hi, vecs[i].lo);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy_ignore();
        int          done_cnt = 0;
        int          done_cyc = -1;
        logic [31:0] hi_s = '0;
        logic [31:0] lo_s = '0;
        logic        dz_s = 1'b1;
        a_in       = 32'hFFFFFF9C;   // -100
        b_in       = 32'd250;
        mult_start = 1'b1;
        @(posedge clk); #1;
        mult_start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin
                div_start = 1'b1;
                a_in      = 32'h0000DEAD;
                b_in      = 32'h0;
            end
            if (c == 6) div_start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                hi_s     = hi_out;
                lo_s     = lo_out;
                dz_s     = div_zero;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc != 33) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected 33", done_cyc); end
        n_checks++; if (hi_s !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL ignore_hi: got %h expected ffffffff", hi_s); end
        n_checks++; if (lo_s !== 32'hFFFF9E58) begin n_fail++; $display("FAIL ignore_lo: got %h expected ffff9e58", lo_s); end
        n_checks++; if (dz_s !== 1'b0) begin n_fail++; $display("FAIL ignore_div_zero: got %b expected 0", dz_s); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        a_in      = 32'd100;
        b_in      = 32'd7;
        div_start = 1'b1;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b expected 0", done); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL rmid_hi: got %h expected 00000000", hi_out); end
        n_checks++; if (lo_out !== 32'h0) begin n_fail++; $display("FAIL rmid_lo: got %h expected 00000000", lo_out); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || lo_out !== 32'h0) begin n_fail++; $display("FAIL rmid_no_resume: got busy=%b lo=%h expected busy=0 lo=00000000", busy, lo_out); end
        run_op(1'b0, 32'd2, 32'd2, cyc);
        n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL rmid_mult_latency: got %0d expected 33", cyc); end
        n_checks++; if (lo_out !== 32'd4) begin n_fail++; $display("FAIL rmid_mult_lo: got %h expected 00000004", lo_out); end
        n_checks++; if (hi_out !== 32'h0) begin n_fail++; $display("FAIL rmid_mult_hi: got %h expected 00000000", hi_out); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_zero();
        test_min_values();
        test_signs();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
